// File: rtl/qsys_system_led_sequencer.sv
// Status LED owner: alarm blink, programmed blink sequence, playback, static.
// Avalon-MM slave with zero-latency reads and a sequence-done interrupt.
module qsys_system_led_sequencer #(
  parameter int PRESCALE   = 50000,
  parameter int ALARM_HALF = 125,
  parameter int HALF_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        alarm_req,
  input  logic        play_req,
  output logic [1:0]  led_out,
  output logic        irq
);

  localparam int PW = $clog2(PRESCALE);
  localparam int AW = $clog2(ALARM_HALF + 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  state_t            state_q, state_d;
  logic [HALF_W-1:0] phase_q, phase_d;
  logic [7:0]        rem_q, rem_d;
  logic              irq_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic              aph_q, aph_d;
  logic [AW-1:0]     acnt_q, acnt_d;
  logic              alarm_q;
  logic [1:0]        static_q, static_d;
  logic [1:0]        pattern_q, pattern_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [1:0]        led_d;

  logic              wr;
  logic              cmd_wr;
  logic              start;
  logic              abort;
  logic              tick;
  logic              seq_step;
  logic              phase_end;
  logic [HALF_W-1:0] half_eff;
  logic              unused_wd;

  assign unused_wd = ^writedata;

  assign wr        = chipselect && !write_n;
  assign cmd_wr    = wr && (address == 2'd3);
  assign start     = cmd_wr && (writedata[7:0] != 8'd0);
  assign abort     = cmd_wr && !start;
  assign tick      = (pre_q == PW'(PRESCALE - 1));
  assign half_eff  = (half_q == '0) ? HALF_W'(1) : half_q;
  assign seq_step  = tick && !alarm_req && (state_q != IDLE);
  assign phase_end = (phase_q <= HALF_W'(1));

  always_comb begin
    static_d  = static_q;
    pattern_d = pattern_q;
    half_d    = half_q;
    if (wr) begin
      case (address)
        2'd0:    static_d  = writedata[1:0];
        2'd1:    pattern_d = writedata[1:0];
        2'd2:    half_d    = writedata[HALF_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    irq_d   = irq;
    if (start) begin
      state_d = ON;
      phase_d = half_eff;
      rem_d   = writedata[7:0];
      irq_d   = 1'b0;
    end else if (abort) begin
      state_d = IDLE;
      rem_d   = 8'd0;
      if (writedata[31]) irq_d = 1'b0;
    end else if (seq_step) begin
      if (phase_end) begin
        phase_d = half_eff;
        if (state_q == ON) begin
          state_d = OFF;
        end else begin
          rem_d = (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
          if (rem_d == 8'd0) begin
            state_d = IDLE;
            irq_d   = 1'b1;
          end else begin
            state_d = ON;
          end
        end
      end else begin
        phase_d = phase_q - HALF_W'(1);
      end
    end
  end

  // Prescaler restarts on a start so the first tick lands PRESCALE cycles later.
  assign pre_d = (start || tick) ? '0 : pre_q + PW'(1);

  always_comb begin
    aph_d  = aph_q;
    acnt_d = acnt_q;
    if (alarm_req && !alarm_q) begin
      aph_d  = 1'b1;
      acnt_d = AW'(ALARM_HALF);
    end else if (alarm_req && tick) begin
      if (acnt_q <= AW'(1)) begin
        aph_d  = !aph_q;
        acnt_d = AW'(ALARM_HALF);
      end else begin
        acnt_d = acnt_q - AW'(1);
      end
    end
  end

  always_comb begin
    led_d = static_d;
    if (alarm_req)            led_d = aph_d ? 2'b11 : 2'b00;
    else if (state_d == ON)   led_d = pattern_d;
    else if (state_d == OFF)  led_d = 2'b00;
    else if (play_req)        led_d = 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      rem_q     <= '0;
      irq       <= 1'b0;
      pre_q     <= '0;
      aph_q     <= 1'b0;
      acnt_q    <= '0;
      alarm_q   <= 1'b0;
      static_q  <= '0;
      pattern_q <= '0;
      half_q    <= '0;
      led_out   <= 2'b00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      irq       <= irq_d;
      pre_q     <= pre_d;
      aph_q     <= aph_d;
      acnt_q    <= acnt_d;
      alarm_q   <= alarm_req;
      static_q  <= static_d;
      pattern_q <= pattern_d;
      half_q    <= half_d;
      led_out   <= led_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[1:0] = static_q;
      2'd1:    readdata[1:0] = pattern_q;
      2'd2:    readdata[HALF_W-1:0] = half_q;
      default: readdata[9:0] = {irq, state_q != IDLE, rem_q};
    endcase
  end

endmodule

// File: tb/tb_qsys_system_led_sequencer.sv
// Bench for qsys_system_led_sequencer: tick-count model plus
// directed sequences with literal expectations.
module tb_qsys_system_led_sequencer;

  localparam int P  = 4;
  localparam int AH = 2;
  localparam int HW = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        alarm_req = 1'b0;
  logic        play_req = 1'b0;
  logic [1:0]  led_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qsys_system_led_sequencer #(
    .PRESCALE(P),
    .ALARM_HALF(AH),
    .HALF_W(HW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .alarm_req(alarm_req),
    .play_req(play_req),
    .led_out(led_out),
    .irq(irq)
  );

  // Model: sequence progress is the count of ticks consumed while no alarm.
  int          m_edge = 0;
  int          m_anchor = 0;
  int          m_consumed = 0;
  int          m_n = 0;
  int          m_half = 1;
  int          m_aticks = 0;
  int          m_cmd_n = 0;
  bit          m_busy = 0;
  bit          m_irq = 0;
  bit          m_alarm_prev = 0;
  bit          m_tick = 0;
  bit          m_cmd = 0;
  logic [1:0]  m_static = '0;
  logic [1:0]  m_pattern = '0;
  logic [HW-1:0] m_halfreg = '0;
  logic [1:0]  m_led = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edge = 0; m_anchor = 0; m_consumed = 0; m_n = 0;
      m_half = 1; m_aticks = 0; m_busy = 0; m_irq = 0;
      m_alarm_prev = 0; m_static = '0; m_pattern = '0;
      m_halfreg = '0; m_led = '0;
    end else begin
      m_edge++;
      m_tick = ((m_edge - m_anchor) % P) == 0;
      m_cmd = 0;
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_static = writedata[1:0];
          2'd1: m_pattern = writedata[1:0];
          2'd2: m_halfreg = writedata[HW-1:0];
          default: begin
            m_cmd = 1;
            m_cmd_n = int'(writedata[7:0]);
            m_consumed = 0;
            if (m_cmd_n > 0) begin
              m_busy = 1; m_n = m_cmd_n; m_irq = 0;
              m_half = (m_halfreg == 0) ? 1 : int'(m_halfreg);
              m_anchor = m_edge;
            end else begin
              m_busy = 0; m_n = 0;
              if (writedata[31]) m_irq = 0;
            end
          end
        endcase
      end
      if (!m_cmd && m_busy && m_tick && !alarm_req) begin
        m_consumed++;
        if (m_consumed == 2 * m_n * m_half) begin
          m_busy = 0; m_irq = 1;
        end
      end
      if (alarm_req && !m_alarm_prev) m_aticks = 0;
      else if (alarm_req && m_tick) m_aticks++;
      m_alarm_prev = alarm_req;
      if (alarm_req)
        m_led = ((m_aticks / AH) % 2 == 0) ? 2'b11 : 2'b00;
      else if (m_busy)
        m_led = ((m_consumed / m_half) % 2 == 0) ? m_pattern : 2'b00;
      else if (play_req)
        m_led = 2'b01;
      else
        m_led = m_static;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] r;
    int rem;
    r = '0;
    case (a)
      2'd0: r[1:0] = m_static;
      2'd1: r[1:0] = m_pattern;
      2'd2: r[HW-1:0] = m_halfreg;
      default: begin
        rem = m_busy ? m_n - m_consumed / (2 * m_half) : 0;
        r = {22'd0, m_irq, m_busy, rem[7:0]};
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #1;
    chk("model_led", {30'd0, led_out}, {30'd0, m_led});
    chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
    chk("model_rd", readdata, exp_rd(address));
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input bit cs = 1'b1);
    @(negedge clk);
    address = a; writedata = d; chipselect = cs; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic lit(input string name, input logic [1:0] led,
                     input logic iq);
    chk({name, "_led"}, {30'd0, led_out}, {30'd0, led});
    chk({name, "_irq"}, {31'd0, irq}, {31'd0, iq});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    address = 2'd3;
    #1 lit("reset_state", 2'b00, 1'b0);
    chk("reset_status", readdata, 32'h0);

    // reset in the middle of a running sequence
    wr(1, 3); wr(2, 2); wr(3, 2);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 lit("async_reset", 2'b00, 1'b0);
    chk("async_reset_status", readdata, 32'h0);
    @(negedge clk);
    #1 chk("reset_held_status", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1 lit("after_release", 2'b00, 1'b0);
    chk("after_release_status", readdata, 32'h0);

    wr(0, 2);
    #1 lit("static", 2'b10, 1'b0);
    chk("static_rd", readdata, 32'h2);
    wr(0, 1, 1'b0);
    #1 chk("no_cs_rd", readdata, 32'h2);
    chk("no_cs_led", {30'd0, led_out}, 32'h2);

    // plain two-blink sequence, 8-cycle phases
    wr(1, 3); wr(2, 2); wr(3, 2);
    #1 lit("seq_on_first", 2'b11, 1'b0);
    chk("seq_status_busy", readdata, 32'h102);
    repeat (7) @(negedge clk);
    #1 lit("seq_on_last", 2'b11, 1'b0);
    @(negedge clk);
    #1 lit("seq_off_first", 2'b00, 1'b0);
    repeat (23) @(negedge clk);
    #1 lit("seq_before_done", 2'b00, 1'b0);
    @(negedge clk);
    #1 lit("seq_done", 2'b10, 1'b1);
    chk("seq_done_status", readdata, 32'h200);

    // same sequence with a 20-cycle alarm inside the first ON phase
    wr(3, 2);
    repeat (2) @(negedge clk);
    alarm_req = 1'b1;
    @(negedge clk);
    #1 lit("alarm_first", 2'b11, 1'b0);
    repeat (5) @(negedge clk);
    #1 lit("alarm_toggle_off", 2'b00, 1'b0);
    repeat (8) @(negedge clk);
    #1 lit("alarm_toggle_on", 2'b11, 1'b0);
    repeat (6) @(negedge clk);
    alarm_req = 1'b0;
    @(negedge clk);
    #1 lit("alarm_resume_on", 2'b11, 1'b0);
    chk("alarm_resume_status", readdata, 32'h102);
    repeat (28) @(negedge clk);
    #1 lit("alarm_before_done", 2'b00, 1'b0);
    @(negedge clk);
    #1 lit("alarm_delayed_done", 2'b10, 1'b1);

    // playback indication around a one-blink sequence
    play_req = 1'b1;
    @(negedge clk);
    #1 lit("play_idle", 2'b01, 1'b1);
    wr(3, 1);
    #1 lit("play_seq_on", 2'b11, 1'b0);
    repeat (15) @(negedge clk);
    #1 lit("play_seq_off", 2'b00, 1'b0);
    @(negedge clk);
    #1 lit("play_after", 2'b01, 1'b1);
    play_req = 1'b0;

    // abort leaves irq clear
    wr(3, 3);
    repeat (4) @(negedge clk);
    wr(3, 0);
    #1 lit("abort", 2'b10, 1'b0);
    chk("abort_status", readdata, 32'h0);

    // HALF=0 behaves as 1 tick per phase
    wr(2, 0); wr(3, 1);
    #1 lit("half0_on", 2'b11, 1'b0);
    repeat (4) @(negedge clk);
    #1 lit("half0_off", 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    #1 lit("half0_done", 2'b10, 1'b1);
    wr(3, 32'h8000_0000);
    #1 lit("irq_clear", 2'b10, 1'b0);
    chk("irq_clear_status", readdata, 32'h0);

    // restart while busy, then start-with-clear when irq is set
    wr(2, 2); wr(3, 2);
    repeat (6) @(negedge clk);
    wr(3, 1);
    #1 chk("restart_status", readdata, 32'h101);
    repeat (16) @(negedge clk);
    #1 lit("restart_done", 2'b10, 1'b1);
    wr(3, 32'h8000_0002);
    #1 lit("start_over_clear", 2'b11, 1'b0);
    chk("start_over_clear_status", readdata, 32'h102);
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qsys_system_led_sequencer.md
Name: qsys_system_led_sequencer

Overview:
- Avalon-MM slave controller that owns the 2-bit status LED lines and decides what they show.
- Arbitrates between three sources: a hardware alarm request (fast blink), a software-programmed blink sequence, and a hardware playback indication.
- Falls back to a static software value when no source is active.
- Sits between the Nios II data master and the board LED pins, replacing direct PIO drive; raises an interrupt when a programmed blink sequence completes.

Parameters:
- PRESCALE, 50000, clk cycles per tick (1 ms at 50 MHz); minimum 2.
- ALARM_HALF, 125, alarm blink half-period in ticks.
- HALF_W, 16, width of the programmable half-period register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero read latency
- alarm_req  in  1  level; alarm active
- play_req  in  1  level; playback active
- led_out  out  2  LED drive, registered
- irq  out  1  sequence-done interrupt, level

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: all registers 0, state IDLE, led_out=00, irq=0, prescaler=0, readdata reflects the reset values.

Register map (a write is chipselect && !write_n; unused bits read 0):
- 0 STATIC rw [1:0]: LED value when no source is active.
- 1 PATTERN rw [1:0]: LED value during the sequence ON phase.
- 2 HALF rw [HALF_W-1:0]: ON/OFF phase length in ticks. 0 is treated as 1.
- 3 CMD/STATUS, write:
  - [7:0]=N: N>0 starts or restarts a sequence of N blinks; N=0 aborts to IDLE without setting irq.
  - bit31=1 clears irq.
  - Any write to address 3 with N>0 also clears irq; start wins over clear.
- 3 CMD/STATUS, read: [7:0] remaining blinks, bit8 busy (state!=IDLE), bit9 irq.

Prescaler:
- Counts 0..PRESCALE-1; tick is a 1-cycle pulse when count==PRESCALE-1.
- Reset to 0 on a sequence start, so the first tick occurs exactly PRESCALE cycles after the start write.

Sequencer FSM (IDLE, ON, OFF):
- Start write: next state ON, phase counter loaded with HALF, remaining=N.
- ON/OFF on tick while alarm_req=0: phase counter decrements. When it is 1 on a tick, the phase ends and the counter reloads with HALF. Each phase therefore lasts HALF*PRESCALE cycles.
- ON end: go to OFF.
- OFF end: remaining decrements. If the result is 0, go to IDLE and set irq; otherwise go to ON.
- HALF written mid-sequence: takes effect at the next phase reload.
- While alarm_req=1, ticks are ignored by the sequencer, so state, phase counter and remaining are frozen. The sequence resumes when alarm_req falls.

Alarm blinker:
- On alarm_req rising edge: alarm_phase=1 and the alarm counter is loaded with ALARM_HALF.
- Thereafter alarm_phase toggles every ALARM_HALF ticks while alarm_req=1.
- The prescaler runs continuously, except for the reset on sequence start.

Output priority (registered; led_out updates on the clock edge after any source change, i.e. 1-cycle latency):
1. alarm_req=1: led_out = alarm_phase ? 11 : 00
2. state ON: led_out = PATTERN
3. state OFF: led_out = 00
4. play_req=1: led_out = 01
5. otherwise: led_out = STATIC

Boundary cases:
- Start while busy restarts cleanly, with no irq for the aborted run.
- Remaining never underflows.
- Reset mid-sequence returns to IDLE with led_out=00 and irq=0 immediately (asynchronous).
- A write with chipselect=0 has no effect.

Test Plan (PRESCALE=4, ALARM_HALF=2):
- Reset asserted mid-sequence -> led_out=00, irq=0, status read = 0 while reset is held and on the first cycle after release.
- Write STATIC=10, then read address 0 -> led_out=10 one cycle after the write; readdata=0x00000002.
- PATTERN=11, HALF=2, then write CMD N=2:
  - led_out=11 for 8 cycles, then 00 for 8 cycles, repeated twice.
  - irq rises one cycle after the final OFF ends.
  - Status read = 0x200; led_out returns to STATIC.
- Same sequence with alarm_req pulsed high for 20 cycles during the first ON phase:
  - led_out shows 11/00 toggling every 8 cycles during the pulse.
  - After the pulse the sequence resumes with the remaining ON time intact.
  - Total completion is delayed by exactly 20 cycles, up to tick alignment of 4.
- play_req=1 with the sequencer idle -> led_out=01. Then start N=1 -> led_out=PATTERN. After completion led_out=01 again.
- Start N=3, then write CMD N=0 after 5 cycles -> IDLE next cycle, irq stays 0. Then write bit31 with irq=1 -> irq=0.
